// File: rtl/reu_pkg.sv
// Shared definitions for the expansion-RAM arbiter slice.
//   state_t    : arbiter FSM encoding (ST_IDLE / ST_BUSY)
//   MAX_PORTS  : upper bound on the number of requesters
//   wrap_add   : modulo-n index increment used by the round-robin search
package reu_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam int MAX_PORTS = 4;

    // (base + step) mod n, returned as a 2-bit port index.
    function automatic logic [1:0] wrap_add(input logic [1:0] base, input int step, input int n);
        int s;
        s = (int'(base) + step) % n;
        return s[1:0];
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational winner selection for the RAM arbiter.
//   pending    in  ports  one bit per requester with an outstanding request
//   last_grant in  2      index of the current/last owner
//   fixed_prio in  1      1 = lowest pending index wins, 0 = round-robin
//   winner     out 2      selected port (0 when nothing is pending)
//   found      out 1      1 when at least one port is pending
module rr_pick
    import reu_pkg::*;
#(
    parameter int ports = 2
) (
    input  logic [ports-1:0] pending,
    input  logic [1:0]       last_grant,
    input  logic             fixed_prio,
    output logic [1:0]       winner,
    output logic             found
);

    // Widened copy so a 2-bit index is always in range.
    logic [MAX_PORTS-1:0] pend_ext;
    logic [1:0]           idx;

    always_comb begin
        pend_ext             = '0;
        pend_ext[ports-1:0]  = pending;
        winner               = 2'd0;
        found                = 1'b0;
        idx                  = 2'd0;
        if (fixed_prio) begin
            // Scan high to low so the lowest pending index is written last.
            for (int i = ports - 1; i >= 0; i--) begin
                if (pend_ext[i]) begin
                    winner = 2'(i);
                    found  = 1'b1;
                end
            end
        end else begin
            // Scan from the farthest candidate (the last owner itself, a full
            // wrap away) down to last_grant+1, so the nearest candidate after
            // the last owner wins and the last owner only wins when alone.
            for (int k = ports; k >= 1; k--) begin
                idx = wrap_add(last_grant, k, ports);
                if (pend_ext[idx]) begin
                    winner = idx;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/reu_ram_arbiter.sv
// Shares one expansion-RAM port among 2..4 toggle-handshake requesters.
// Each accepted request becomes exactly one downstream RAM cycle; the read
// result of the latest completed read is returned on the shared req_q bus.
//   clk, reset : clock, synchronous active-high reset
//   req_a/d/we : per-port address / write data / write enable (slice i = port i)
//   req_req    : per-port request toggle (pending while req_req != req_ack)
//   req_ack    : per-port acknowledge toggle
//   req_q      : read data of the most recently completed read
//   ram_a/d/we : registered RAM address / write data / write enable
//   ram_req    : RAM request toggle (cycle outstanding while ram_req != ram_ack)
//   ram_ack    : RAM acknowledge toggle
//   ram_q      : RAM read data
//   grant      : current or last owner
//   busy       : 1 while a RAM cycle is outstanding
module reu_ram_arbiter
    import reu_pkg::*;
#(
    parameter int ram_a_bits = 17,
    parameter int ports      = 2,
    parameter int fixed_prio = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [ports*ram_a_bits-1:0] req_a,
    input  logic [ports*8-1:0]          req_d,
    input  logic [ports-1:0]            req_we,
    input  logic [ports-1:0]            req_req,
    output logic [ports-1:0]            req_ack,
    output logic [7:0]                  req_q,
    output logic [ram_a_bits-1:0]       ram_a,
    output logic [7:0]                  ram_d,
    input  logic [7:0]                  ram_q,
    output logic                        ram_we,
    output logic                        ram_req,
    input  logic                        ram_ack,
    output logic [1:0]                  grant,
    output logic                        busy
);

    state_t                 state_reg,   state_next;
    logic [1:0]             grant_reg,   grant_next;
    logic                   busy_reg,    busy_next;
    logic [ram_a_bits-1:0]  ram_a_reg,   ram_a_next;
    logic [7:0]             ram_d_reg,   ram_d_next;
    logic                   ram_we_reg,  ram_we_next;
    logic                   ram_req_reg, ram_req_next;
    logic [7:0]             req_q_reg,   req_q_next;
    logic [ports-1:0]       req_ack_reg, req_ack_next;

    // Per-port slices unpacked to MAX_PORTS entries; unused entries read as 0
    // so the 2-bit winner index never selects outside the array.
    logic [ram_a_bits-1:0]  slice_a  [MAX_PORTS];
    logic [7:0]             slice_d  [MAX_PORTS];
    logic                   slice_we [MAX_PORTS];

    genvar gi;
    generate
        for (gi = 0; gi < MAX_PORTS; gi++) begin : g_slice
            if (gi < ports) begin : g_used
                assign slice_a[gi]  = req_a[gi*ram_a_bits +: ram_a_bits];
                assign slice_d[gi]  = req_d[gi*8 +: 8];
                assign slice_we[gi] = req_we[gi];
            end else begin : g_unused
                assign slice_a[gi]  = '0;
                assign slice_d[gi]  = '0;
                assign slice_we[gi] = 1'b0;
            end
        end
    endgenerate

    logic [ports-1:0] pending;
    logic [1:0]       winner;
    logic             found;

    assign pending = req_req ^ req_ack_reg;

    rr_pick #(
        .ports      (ports)
    ) u_pick (
        .pending    (pending),
        .last_grant (grant_reg),
        .fixed_prio (fixed_prio != 0),
        .winner     (winner),
        .found      (found)
    );

    always_comb begin
        state_next   = state_reg;
        grant_next   = grant_reg;
        busy_next    = busy_reg;
        ram_a_next   = ram_a_reg;
        ram_d_next   = ram_d_reg;
        ram_we_next  = ram_we_reg;
        ram_req_next = ram_req_reg;
        req_q_next   = req_q_reg;
        req_ack_next = req_ack_reg;
        case (state_reg)
            ST_IDLE: begin
                if (found) begin
                    ram_a_next   = slice_a[winner];
                    ram_d_next   = slice_d[winner];
                    ram_we_next  = slice_we[winner];
                    ram_req_next = ~ram_req_reg;
                    grant_next   = winner;
                    busy_next    = 1'b1;
                    state_next   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (ram_req_reg == ram_ack) begin
                    if (!ram_we_reg) begin
                        req_q_next = ram_q;
                    end
                    for (int i = 0; i < ports; i++) begin
                        if (grant_reg == 2'(i)) begin
                            req_ack_next[i] = ~req_ack_reg[i];
                        end
                    end
                    busy_next  = 1'b0;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            grant_reg   <= 2'd0;
            busy_reg    <= 1'b0;
            ram_a_reg   <= '0;
            ram_d_reg   <= '0;
            ram_we_reg  <= 1'b0;
            req_q_reg   <= '0;
            // Resynchronise both handshakes: any in-flight RAM cycle is
            // abandoned and pending requests are dropped without an ack.
            ram_req_reg <= ram_ack;
            req_ack_reg <= req_req;
        end else begin
            state_reg   <= state_next;
            grant_reg   <= grant_next;
            busy_reg    <= busy_next;
            ram_a_reg   <= ram_a_next;
            ram_d_reg   <= ram_d_next;
            ram_we_reg  <= ram_we_next;
            req_q_reg   <= req_q_next;
            ram_req_reg <= ram_req_next;
            req_ack_reg <= req_ack_next;
        end
    end

    assign req_ack = req_ack_reg;
    assign req_q   = req_q_reg;
    assign ram_a   = ram_a_reg;
    assign ram_d   = ram_d_reg;
    assign ram_we  = ram_we_reg;
    assign ram_req = ram_req_reg;
    assign grant   = grant_reg;
    assign busy    = busy_reg;

endmodule
